uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 112 +++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits LSB first, SB_TICK/16 stop bits, paced by a 16x s_tick.
// tx drops on the accepting edge; tx_start outside IDLE is ignored (tx_ready is the only handshake).
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx_done_tick,
    output logic       tx
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [4:0] BIT_LAST  = 5'd15;
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] DATA_LAST = 3'(DBIT - 1);

    state_t     state, state_next;
    logic [4:0] tick_cnt, tick_cnt_next;
    logic [2:0] bit_cnt, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic       tx_next;
    logic       done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            tx           <= 1'b1;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            tick_cnt     <= tick_cnt_next;
            bit_cnt      <= bit_cnt_next;
            shift_reg    <= shift_next;
            tx           <= tx_next;
            tx_done_tick <= done_next;
        end
    end

    // tx is registered, so each branch computes the line level for the coming bit.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        tx_next       = tx;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_start) begin
                    state_next    = START;
                    shift_next    = din;
                    tick_cnt_next = '0;
                    bit_cnt_next  = '0;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        state_next    = DATA;
                        tick_cnt_next = '0;
                        bit_cnt_next  = '0;
                        tx_next       = shift_reg[0];
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_cnt == BIT_LAST) begin
                        tick_cnt_next = '0;
                        shift_next    = {1'b0, shift_reg[7:1]};
                        if (bit_cnt == DATA_LAST) begin
                            state_next = STOP;
                            tx_next    = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt + 3'd1;
                            tx_next      = shift_reg[1];
                        end
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_cnt == STOP_LAST) begin
                        state_next    = IDLE;
                        tick_cnt_next = '0;
                        done_next     = 1'b1;
                    end else begin
                        tick_cnt_next = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx_ready = (state == IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a line monitor rebuilds each frame tick by tick and checks it against a queue of
// bytes pushed at send time; one default instance and one DBIT=7/SB_TICK=32 instance, selected by sel.
`timescale 1ns/1ps
module tb_uart_tx;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       s_tick;
    logic       sel;
    logic       tx_start0, tx_start1;
    logic [7:0] din0, din1;
    logic       tx_ready0, tx_done_tick0, tx0;
    logic       tx_ready1, tx_done_tick1, tx1;

    uart_tx dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start0), .din(din0),
        .tx_ready(tx_ready0), .tx_done_tick(tx_done_tick0), .tx(tx0)
    );

    uart_tx #(.DBIT(7), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start1), .din(din1),
        .tx_ready(tx_ready1), .tx_done_tick(tx_done_tick1), .tx(tx1)
    );

    logic mon_tx, mon_rdy, mon_done;
    assign mon_tx   = sel ? tx1 : tx0;
    assign mon_rdy  = sel ? tx_ready1 : tx_ready0;
    assign mon_done = sel ? tx_done_tick1 : tx_done_tick0;

    int checks = 0;
    int failures = 0;
    int frames_sent = 0;
    int frames_seen = 0;
    int mon_ticks = 0;
    int rdy_bad = 0;
    bit busy = 1'b0;
    bit exp_done = 1'b0;
    logic lvl [0:255];
    logic [7:0] exp_q [$];

    bit tick_en = 1'b1;
    int tick_div = 4;
    int tick_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Decode the recorded per-tick line levels of one frame and compare against the scoreboard.
    task automatic finish_frame();
        int mdbit, msb, start_bad, glitch, stop_bad;
        logic [7:0] got, e;
        mdbit = sel ? 7 : 8;
        msb = sel ? 32 : 16;
        start_bad = 0; glitch = 0; stop_bad = 0; got = '0;
        for (int i = 0; i < 16; i++) if (lvl[i] !== 1'b0) start_bad++;
        for (int k = 0; k < mdbit; k++) begin
            got[k] = lvl[16*(k+1)+8];
            for (int j = 0; j < 16; j++) if (lvl[16*(k+1)+j] !== lvl[16*(k+1)+8]) glitch++;
        end
        for (int i = 0; i < msb; i++) if (lvl[16*(1+mdbit)+i] !== 1'b1) stop_bad++;
        check_eq("frame_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("frame_data", got, e);
        end
        check_eq("start_bit_ticks", start_bad, 0);
        check_eq("data_bit_stable", glitch, 0);
        check_eq("stop_bit_ticks", stop_bad, 0);
        check_eq("ready_low_in_frame", rdy_bad, 0);
        frames_seen++;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                check_eq("done_tick_timing", mon_done, 1);
                exp_done = 1'b0;
                finish_frame();
            end else if (mon_done === 1'b1) begin
                check_eq("spurious_done", mon_done, 0);
            end
            if (!busy && !exp_done && mon_tx === 1'b0) begin
                busy = 1'b1;
                mon_ticks = 0;
                rdy_bad = 0;
            end
            if (busy) begin
                if (mon_rdy !== 1'b0) rdy_bad++;
                if (s_tick) begin
                    lvl[mon_ticks] = mon_tx;
                    mon_ticks++;
                    if (mon_ticks == 16 * (1 + (sel ? 7 : 8)) + (sel ? 32 : 16)) begin
                        busy = 1'b0;
                        exp_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (tick_en && tick_cnt >= tick_div - 1) begin
                s_tick = 1'b1;
                tick_cnt = 0;
            end else begin
                s_tick = 1'b0;
                if (tick_en) tick_cnt++;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        if (sel) begin tx_start1 = 1'b1; din1 = b; end
        else begin tx_start0 = 1'b1; din0 = b; end
        exp_q.push_back(b & (sel ? 8'h7F : 8'hFF));
        frames_sent++;
        @(posedge clk); #1;
        tx_start0 = 1'b0;
        tx_start1 = 1'b0;
        din0 = 8'($urandom);
        din1 = 8'($urandom);
        check_eq("accept_tx_low", mon_tx, 0);
        check_eq("accept_not_ready", mon_rdy, 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || exp_done) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(n < budget), 1);
    endtask

    task automatic wait_ticks(input string tag, input int target, input int budget);
        int n = 0;
        while (mon_ticks != target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(n < budget), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (mon_done !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq(tag, 32'(n < budget), 1);
    endtask

    initial begin
        logic frozen_tx;
        int   frozen_ticks;
        sel = 1'b0;
        reset = 1'b1;
        tx_start0 = 1'b0; tx_start1 = 1'b0;
        din0 = 8'h00; din1 = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_tx", {tx1, tx0}, 2'b11);
        check_eq("reset_ready", {tx_ready1, tx_ready0}, 2'b11);
        check_eq("reset_done", {tx_done_tick1, tx_done_tick0}, 2'b00);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        send(8'hA5);
        wait_idle("a5_frame_timeout", 2000);

        // Second request lands in the done cycle; its start bit must begin on that edge.
        send(8'h00);
        wait_done("b2b_done_timeout", 2000);
        send(8'hFF);
        wait_idle("b2b_frame_timeout", 3000);

        send(8'h81);
        wait_ticks("ignore_wait_timeout", 40, 2000);
        tx_start0 = 1'b1; din0 = 8'h3C;
        @(posedge clk); #1;
        tx_start0 = 1'b0;
        check_eq("ignored_start_ready", tx_ready0, 0);
        wait_idle("ignore_frame_timeout", 2000);
        repeat (200) @(posedge clk);
        #1;
        check_eq("no_extra_frame", frames_seen, frames_sent);

        send(8'h6B);
        wait_ticks("freeze_wait_timeout", 50, 2000);
        tick_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        frozen_tx = tx0;
        frozen_ticks = mon_ticks;
        repeat (1000) @(posedge clk);
        #1;
        check_eq("freeze_tx", tx0, frozen_tx);
        check_eq("freeze_ticks", mon_ticks, frozen_ticks);
        check_eq("freeze_ready", tx_ready0, 0);
        tick_en = 1'b1;
        wait_idle("freeze_frame_timeout", 2000);

        send(8'h55);
        wait_ticks("abort_wait_timeout", 70, 2000);
        reset = 1'b1;
        tx_start0 = 1'b1; din0 = 8'hEE;
        @(posedge clk); #1;
        reset = 1'b0;
        tx_start0 = 1'b0;
        check_eq("abort_tx_high", tx0, 1);
        check_eq("abort_no_done", tx_done_tick0, 0);
        check_eq("abort_ready", tx_ready0, 1);
        exp_q.delete();
        frames_sent--;
        repeat (100) @(posedge clk);
        #1;
        check_eq("abort_line_idle", tx0, 1);
        send(8'h0F);
        wait_idle("after_abort_timeout", 2000);

        // s_tick every cycle, so one arrives in the accepting cycle and must not be counted.
        tick_div = 1;
        send(8'h96);
        wait_idle("fast_tick_timeout", 1000);
        tick_div = 4;

        sel = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(8'hC3);
        wait_idle("dbit7_frame_timeout", 2000);

        repeat (300) @(posedge clk);
        #1;
        check_eq("frame_count", frames_seen, frames_sent);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
